// File: rtl/sram_serial_loader.sv
`default_nettype none
// ============================================================================
// Module   : sram_serial_loader
// Brief    : Bit-serial frame to SRAM write-strobe bridge with serial read-back.
// Revision : 1.0 - initial release
// ============================================================================
module sram_serial_loader #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 10
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         BGN,
  input  logic [1:0]                   MODE,
  input  logic                         SI,
  output logic                         SO,
  output logic                         RDY,
  output logic                         DONE,
  output logic                         CEN,
  output logic                         WEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D,
  input  logic [MEMORY_DATA_WIDTH-1:0] Q
);

  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam int DW = MEMORY_DATA_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_CNT    = 3'd2;
  localparam logic [2:0] S_WDATA  = 3'd3;
  localparam logic [2:0] S_RREQ   = 3'd4;
  localparam logic [2:0] S_RLOAD  = 3'd5;
  localparam logic [2:0] S_RSHIFT = 3'd6;
  localparam logic [2:0] S_FIN    = 3'd7;

  localparam logic [3:0]    LAST_ABIT = 4'(AW - 1);
  localparam logic [3:0]    LAST_DBIT = 4'(DW - 1);
  localparam logic [AW-1:0] ONE_A     = AW'(1);

  logic [2:0]    state_q, state_d;
  logic          rd_mode_q, rd_mode_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] sreg_q, sreg_d;
  logic [DW-1:0] d_q, d_d;
  logic          strobe_q, strobe_d;
  logic          cen_q, cen_d;
  logic          wen_q, wen_d;

  logic field_done;
  logic byte_done;
  logic cnt_zero;
  logic write_end;

  assign field_done = (bit_cnt_q == LAST_ABIT);
  assign byte_done  = (bit_cnt_q == LAST_DBIT);
  assign cnt_zero   = (cnt_q == '0);
  // Strobe cycle of the final byte: no further payload bits are taken.
  assign write_end  = strobe_q && cnt_zero;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (BGN) state_d = (MODE == 2'b01 || MODE == 2'b10) ? S_ADDR : S_FIN;
      S_ADDR:   if (field_done) state_d = S_CNT;
      S_CNT:    if (field_done) state_d = rd_mode_q ? S_RREQ : S_WDATA;
      S_WDATA:  if (write_end) state_d = S_FIN;
      S_RREQ:   state_d = S_RLOAD;
      S_RLOAD:  state_d = S_RSHIFT;
      S_RSHIFT: if (byte_done) state_d = cnt_zero ? S_FIN : S_RREQ;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    RDY  = (state_q == S_IDLE);
    DONE = (state_q == S_FIN);
    SO   = (state_q == S_RSHIFT) ? sreg_q[DW-1] : 1'b0;
    CEN  = cen_q;
    WEN  = wen_q;
    A    = a_q;
    D    = d_q;
  end

  always_comb begin
    rd_mode_d = rd_mode_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    sreg_d    = sreg_q;
    d_d       = d_q;
    strobe_d  = 1'b0;
    cen_d     = 1'b1;
    wen_d     = 1'b1;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        addr_d    = '0;
        cnt_d     = '0;
        sreg_d    = '0;
        if (BGN) rd_mode_d = (MODE == 2'b10);
      end
      S_ADDR: begin
        addr_d    = {addr_q[AW-2:0], SI};
        bit_cnt_d = field_done ? 4'd0 : bit_cnt_q + 4'd1;
      end
      S_CNT: begin
        cnt_d     = {cnt_q[AW-2:0], SI};
        bit_cnt_d = field_done ? 4'd0 : bit_cnt_q + 4'd1;
        if (field_done && rd_mode_q) begin
          cen_d = 1'b0;
          a_d   = addr_q;
        end
      end
      S_WDATA: begin
        if (!write_end) begin
          sreg_d    = {sreg_q[DW-2:0], SI};
          bit_cnt_d = byte_done ? 4'd0 : bit_cnt_q + 4'd1;
          if (strobe_q) begin
            addr_d = addr_q + ONE_A;
            cnt_d  = cnt_q - ONE_A;
          end
          if (byte_done) begin
            d_d      = {sreg_q[DW-2:0], SI};
            a_d      = addr_q;
            cen_d    = 1'b0;
            wen_d    = 1'b0;
            strobe_d = 1'b1;
          end
        end
      end
      S_RLOAD: begin
        sreg_d    = Q;
        bit_cnt_d = '0;
      end
      S_RSHIFT: begin
        sreg_d    = {sreg_q[DW-2:0], 1'b0};
        bit_cnt_d = byte_done ? 4'd0 : bit_cnt_q + 4'd1;
        if (byte_done && !cnt_zero) begin
          addr_d = addr_q + ONE_A;
          cnt_d  = cnt_q - ONE_A;
          cen_d  = 1'b0;
          a_d    = addr_q + ONE_A;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_mode_q <= 1'b0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      sreg_q    <= '0;
      d_q       <= '0;
      strobe_q  <= 1'b0;
      cen_q     <= 1'b1;
      wen_q     <= 1'b1;
    end else begin
      rd_mode_q <= rd_mode_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      sreg_q    <= sreg_d;
      d_q       <= d_d;
      strobe_q  <= strobe_d;
      cen_q     <= cen_d;
      wen_q     <= wen_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_serial_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_serial_loader
// Brief    : Directed frames against a cycle-indexed expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_serial_loader;

  logic       CLK = 1'b0;
  logic       RST, BGN, SI;
  logic [1:0] MODE;
  logic       SO, RDY, DONE, CEN, WEN;
  logic [9:0] A;
  logic [7:0] D, Q;

  always #5 CLK = ~CLK;

  sram_serial_loader #(.MEMORY_DATA_WIDTH(8), .MEMORY_ADDR_WIDTH(10)) dut (
    .CLK(CLK), .RST(RST), .BGN(BGN), .MODE(MODE), .SI(SI), .SO(SO),
    .RDY(RDY), .DONE(DONE), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
  );

  logic [7:0] mem [0:1023];
  always @(posedge CLK) begin
    if (!CEN && !WEN) mem[A] <= D;
    else if (!CEN) Q <= mem[A];
  end

  typedef struct {
    bit       v;
    bit       rdy, done, cen, wen, so, sow;
    bit [9:0] a;
    bit [7:0] d;
  } exp_t;

  exp_t       ex [0:4095];
  int         cyc = 0;
  int         n_cmp = 0, n_fail = 0;
  int         strobes = 0, dones = 0;
  bit [9:0]   m_a;
  bit [7:0]   m_d;
  bit [7:0]   mmem [0:1023];
  bit [7:0]   pay [0:7];
  logic [31:0] so_buf;
  int         cmp_idx;

  always @(posedge CLK) cyc <= cyc + 1;

  // Output checker: cycle index cyc+1 is the cycle following edge number cyc.
  always @(negedge CLK) begin
    cmp_idx = cyc + 1;
    if (!CEN && !WEN) strobes++;
    if (DONE === 1'b1) dones++;
    if (cmp_idx < 4096 && ex[cmp_idx].v) begin
      n_cmp++;
      if ({RDY, DONE, CEN, WEN, SO, A, D} !==
          {ex[cmp_idx].rdy, ex[cmp_idx].done, ex[cmp_idx].cen, ex[cmp_idx].wen,
           ex[cmp_idx].so, ex[cmp_idx].a, ex[cmp_idx].d}) begin
        n_fail++;
        $display("FAIL cycle%0d got RDY=%b DONE=%b CEN=%b WEN=%b SO=%b A=%h D=%h want RDY=%b DONE=%b CEN=%b WEN=%b SO=%b A=%h D=%h",
                 cmp_idx, RDY, DONE, CEN, WEN, SO, A, D,
                 ex[cmp_idx].rdy, ex[cmp_idx].done, ex[cmp_idx].cen, ex[cmp_idx].wen,
                 ex[cmp_idx].so, ex[cmp_idx].a, ex[cmp_idx].d);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // Expected outputs for every cycle of a frame whose BGN is sampled at edge t.
  task automatic plan(input int t, input logic [1:0] mode, input int addr, input int n,
                      output int fin);
    exp_t e;
    bit   wr, rd;
    int   off, k, r;
    wr  = (mode == 2'b01);
    rd  = (mode == 2'b10);
    fin = wr ? t + 30 + 8 * (n - 1) : rd ? t + 21 + 10 * n : t + 1;
    for (int c = t + 1; c <= fin + 1; c++) begin
      e.v = 1; e.rdy = (c == fin + 1); e.done = (c == fin);
      e.cen = 1; e.wen = 1; e.so = 0; e.sow = 0;
      if (wr && c >= t + 29 && c < fin && ((c - t - 29) % 8) == 0) begin
        k = (c - t - 29) / 8;
        m_a = 10'((addr + k) & 1023);
        m_d = pay[k];
        mmem[m_a] = pay[k];
        e.cen = 0; e.wen = 0;
      end
      if (rd && c >= t + 21 && c < fin) begin
        off = c - t - 21; k = off / 10; r = off % 10;
        if (r == 0) begin
          m_a = 10'((addr + k) & 1023);
          e.cen = 0;
        end
        if (r >= 2) begin
          e.so  = mmem[10'((addr + k) & 1023)][9 - r];
          e.sow = 1;
        end
      end
      e.a = m_a; e.d = m_d;
      ex[c] = e;
    end
  endtask

  task automatic run_frame(input logic [1:0] mode, input int addr, input int n,
                           input bit hold, input int abort_off);
    logic [9:0] av, cv;
    bit         bits[$];
    int         t, fin, idx, i, s0;
    av = 10'(addr); cv = 10'(n - 1);
    for (int b = 9; b >= 0; b--) bits.push_back(av[b]);
    for (int b = 9; b >= 0; b--) bits.push_back(cv[b]);
    if (mode == 2'b01)
      for (int k = 0; k < n; k++)
        for (int b = 7; b >= 0; b--) bits.push_back(pay[k][b]);
    so_buf = '0;
    @(negedge CLK);
    t = cyc + 1;
    s0 = strobes;
    plan(t, mode, addr, n, fin);
    BGN = 1'b1; MODE = mode;
    for (int step = 0; step < 3000; step++) begin
      @(negedge CLK);
      idx = cyc + 1;
      i = idx - t - 1;
      if (!hold || idx >= fin) BGN = 1'b0;
      SI = (i >= 0 && i < bits.size()) ? bits[i] : 1'($urandom);
      if (ex[idx].sow) so_buf = {so_buf[30:0], SO};
      if (abort_off != 0 && idx == t + abort_off) begin
        for (int c = idx + 1; c <= fin + 1; c++) ex[c].v = 0;
        #2 RST = 1'b1;
        #1;
        check("abort_cen", CEN, 1);
        check("abort_wen", WEN, 1);
        check("abort_rdy", RDY, 1);
        check("abort_a", A, 0);
        check("abort_strobes", strobes - s0, 1);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0; BGN = 1'b0;
        m_a = '0; m_d = '0;
        return;
      end
      if (idx == fin + 1) return;
    end
    check("frame_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0;
    RST = 1'b1; BGN = 1'b0; MODE = 2'b00; SI = 1'b0;
    m_a = '0; m_d = '0;
    for (int i = 0; i < 1024; i++) begin mem[i] = 8'h00; mmem[i] = 8'h00; end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_rdy", RDY, 1);
    check("rst_cen", CEN, 1);
    check("rst_wen", WEN, 1);
    check("rst_a", A, 0);
    check("rst_so", SO, 0);
    check("rst_done", DONE, 0);

    // Three-byte write at 0x010
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'hFF;
    s0 = strobes; d0 = dones;
    run_frame(2'b01, 'h010, 3, 0, 0);
    check("wr_strobes", strobes - s0, 3);
    check("wr_dones", dones - d0, 1);
    check("wr_mem10", mem[10'h010], 8'hA5);
    check("wr_mem11", mem[10'h011], 8'h3C);
    check("wr_mem12", mem[10'h012], 8'hFF);

    // Address wrap
    pay[0] = 8'h11; pay[1] = 8'h22;
    run_frame(2'b01, 'h3FF, 2, 0, 0);
    check("wrap_mem3ff", mem[10'h3FF], 8'h11);
    check("wrap_mem000", mem[10'h000], 8'h22);

    run_frame(2'b10, 'h3FF, 2, 0, 0);
    check("rd_wrap_so", so_buf[15:0], 16'h1122);

    run_frame(2'b10, 'h010, 3, 0, 0);
    check("rd_so", so_buf[23:0], 24'hA53CFF);

    // BGN held through the frame
    pay[0] = 8'h01; pay[1] = 8'h80;
    s0 = strobes; d0 = dones;
    run_frame(2'b01, 'h020, 2, 1, 0);
    check("hold_strobes", strobes - s0, 2);
    check("hold_dones", dones - d0, 1);
    check("hold_mem21", mem[10'h021], 8'h80);

    // Reset after the 4th bit of the second payload byte
    pay[0] = 8'h5A; pay[1] = 8'hC3; pay[2] = 8'hE7;
    run_frame(2'b01, 'h100, 3, 0, 33);
    check("abort_mem100", mem[10'h100], 8'h5A);
    check("abort_mem101", mem[10'h101], 8'h00);
    mmem[10'h101] = 8'h00; mmem[10'h102] = 8'h00;

    pay[0] = 8'h77;
    run_frame(2'b01, 'h200, 1, 0, 0);
    check("fresh_mem200", mem[10'h200], 8'h77);

    // No-op modes
    s0 = strobes; d0 = dones;
    run_frame(2'b00, 'h0AA, 1, 0, 0);
    run_frame(2'b11, 'h155, 1, 0, 0);
    check("noop_strobes", strobes - s0, 0);
    check("noop_dones", dones - d0, 2);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
